// File: rtl/cpa_seg_add_ctrl_if.sv
// Operand/result handshake bundle for cpa_seg_add_ctrl: valid/ready on the operand side
// and on the result side, plus a busy flag.
interface cpa_seg_add_ctrl_if #(
  parameter int SEG_W   = 8,
  parameter int NUM_SEG = 4
);
  localparam int W = SEG_W * NUM_SEG;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/cpa_seg_add_ctrl.sv
// Wide unsigned adder that time-shares one narrow ripple CPA, one SEG_W-bit segment per cycle.
// Optional macro CPA_SEG_EARLY_EXIT_EN: finish early once the remaining segments cannot change the sum.
module cpa_seg_add_ctrl #(
  parameter int SEG_W   = 8,
  parameter int NUM_SEG = 4
) (
  input  logic              clk,
  input  logic              rst,
  cpa_seg_add_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [IDX_W-1:0]              seg_idx;
  logic                          carry;
  logic [NUM_SEG-1:0][SEG_W-1:0] a_q;
  logic [NUM_SEG-1:0][SEG_W-1:0] b_q;
  logic [NUM_SEG-1:0][SEG_W-1:0] sum_q;
  logic                          sum_top;

  logic [SEG_W:0]   cpa_a;
  logic [SEG_W:0]   cpa_b;
  logic [SEG_W+1:0] cpa_res;
  logic             last_seg;
  logic             early_exit;

  // The CPA has no carry-in; doubling the carry into bit 0 of both operands injects it
  // into bit 1, and bit 0 of the result is always 0 and dropped.
  assign cpa_a    = {a_q[seg_idx], carry};
  assign cpa_b    = {b_q[seg_idx], carry};
  assign last_seg = (seg_idx == IDX_W'(NUM_SEG - 1));

  // NOTE: inside always_comb, blocking '=' is correct -- cy must update in loop order so
  // each bit sees the carry from the bit below it.
  always_comb begin : ripple_cpa
    logic cy;
    cy      = 1'b0;
    cpa_res = '0;
    for (int i = 0; i <= SEG_W; i++) begin
      cpa_res[i] = cpa_a[i] ^ cpa_b[i] ^ cy;
      cy         = (cpa_a[i] & cpa_b[i]) | (cy & (cpa_a[i] ^ cpa_b[i]));
    end
    cpa_res[SEG_W+1] = cy;
  end

`ifdef CPA_SEG_EARLY_EXIT_EN
  logic [NUM_SEG-1:0] upper_zero;

  // upper_zero[k]: every A and B segment above k is zero.
  always_comb begin : zero_detect
    logic z;
    z          = 1'b1;
    upper_zero = '0;
    for (int k = NUM_SEG - 1; k >= 0; k--) begin
      upper_zero[k] = z;
      z             = z & (a_q[k] == '0) & (b_q[k] == '0);
    end
  end

  assign early_exit = !last_seg && !cpa_res[SEG_W+1] && upper_zero[seg_idx];
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_n = RUN;
      end
      RUN: begin
        if (last_seg || early_exit) state_n = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the operand registers carry no reset: they are always loaded at accept before
  // anything reads them, so a reset would only add gating to a wide register.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_q <= bus.in_a;
      b_q <= bus.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_idx <= '0;
      carry   <= 1'b0;
      sum_q   <= '0;
      sum_top <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            seg_idx <= '0;
            carry   <= 1'b0;
            sum_q   <= '0;
            sum_top <= 1'b0;
          end
        end
        RUN: begin
          sum_q[seg_idx] <= cpa_res[SEG_W:1];
          carry          <= cpa_res[SEG_W+1];
          if (last_seg)         sum_top <= cpa_res[SEG_W+1];
          else if (!early_exit) seg_idx <= seg_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_sum = {sum_top, sum_q};
endmodule

// File: tb/tb_cpa_seg_add_ctrl.sv
// Randomized self-checking bench for cpa_seg_add_ctrl against an arithmetic reference model
// (A+B in W+1 bits, latency derived from the segment rules).
module tb_cpa_seg_add_ctrl;
  localparam int SEG_W   = 8;
  localparam int NUM_SEG = 4;
  localparam int W       = SEG_W * NUM_SEG;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpa_seg_add_ctrl_if #(.SEG_W(SEG_W), .NUM_SEG(NUM_SEG)) bus ();

  cpa_seg_add_ctrl #(.SEG_W(SEG_W), .NUM_SEG(NUM_SEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Early-exit point: first segment k after which no carry is pending and nothing above is non-zero.
  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int first_k = -1;
    for (int k = NUM_SEG - 2; k >= 0; k--) begin
      longint unsigned lim = 64'd1 << (SEG_W * (k + 1));
      longint unsigned lo  = (64'(a) % lim) + (64'(b) % lim);
      if (lo < lim && (64'(a) / lim) == 0 && (64'(b) / lim) == 0) first_k = k;
    end
`ifdef CPA_SEG_EARLY_EXIT_EN
    if (first_k >= 0) return first_k + 2;
`endif
    return (first_k >= -1) ? NUM_SEG + 1 : 0;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait (bounded), optional result stall, handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [W:0] exp;
    int         cyc;
    exp = ref_sum(a, b);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 4 * NUM_SEG) begin
      check({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(ref_latency(a, b)));
    check({tag, "_sum"}, 64'(bus.out_sum), 64'(exp));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a     = W'($urandom);
      tick();
      check({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_stall_sum"}, 64'(bus.out_sum), 64'(exp));
      check({tag, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_post_sum_kept"}, 64'(bus.out_sum), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W:0] exp_q[$];
    logic [W:0] exp;
    int         last_t;
    int         n_res;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_out_sum", 64'(bus.out_sum), 64'd0);
    rst = 1'b0;
    tick();

    run_op("t1", 32'h1234_5678, 32'h1111_1111, 0);
    run_op("t2_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("t3_max_stall", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    run_op("t5_small", 32'h0000_0005, 32'h0000_0003, 0);
    run_op("t5_carry1", 32'h0000_00FF, 32'h0000_0001, 0);
    run_op("zero", 32'h0, 32'h0, 1);

    // Reset during the second RUN cycle discards the operation.
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_b     = 32'h0BAD_F00D;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_out_sum", 64'(bus.out_sum), 64'd0);
    run_op("t4_after_rst", 32'h1, 32'h1, 0);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("rand%0d", i), rand_operand(), rand_operand(), $urandom_range(0, 2));

    // Back-to-back: both sides always willing.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = rand_operand();
    bus.in_b      = rand_operand();
    last_t        = -1;
    n_res         = 0;
    for (int t = 0; t < 120; t++) begin
      if (bus.out_valid) begin
        check("b2b_have_expect", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("b2b_sum", 64'(bus.out_sum), 64'(exp));
        end
`ifndef CPA_SEG_EARLY_EXIT_EN
        if (last_t >= 0) check("b2b_interval", 64'(t - last_t), 64'(NUM_SEG + 2));
`endif
        last_t = t;
        n_res++;
      end
      if (bus.in_ready) exp_q.push_back(ref_sum(bus.in_a, bus.in_b));
      tick();
      bus.in_a = rand_operand();
      bus.in_b = rand_operand();
    end
    check("b2b_result_count_ok", 64'(n_res >= 15), 64'd1);
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
